// File: rtl/dti_uart_pkg.sv
// dti_uart_pkg: shared UART capture state encoding and frame data-width helpers
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package dti_uart_pkg;

    localparam int CFG_DATA_WIDTH = `CFG_DATA_WIDTH;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_CLR
    } cap_state_t;

    function automatic int data_bits(input logic [1:0] enc);
        return (enc == DBITS_5) ? 5 :
               (enc == DBITS_6) ? 6 :
               (enc == DBITS_7) ? 7 :
               (enc == DBITS_8) ? 8 : 8;
    endfunction

endpackage

// File: rtl/dti_sync_fifo.sv
// dti_sync_fifo: first-word-fall-through storage with wrapping pointers and a separate level count
module dti_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // when empty, show the last popped slot so stale-but-defined data is presented
    assign rd_data = (level == '0) ? mem[AW'(rd_ptr - 1'b1)] : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_en ? AW'(wr_ptr + 1'b1) : wr_ptr;
            rd_ptr <= rd_en ? AW'(rd_ptr + 1'b1) : rd_ptr;
            level  <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver characters via a done/ack handshake into a FIFO with status flags
module uart_rx_fifo
    import dti_uart_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_done,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic [1:0]                 cfg_data_bit_num,
    input  logic [$clog2(DEPTH):0]     cfg_threshold,
    output logic                       rx_done_ack,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       irq,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int LW = $clog2(DEPTH) + 1;

    cap_state_t            state;
    logic [DATA_WIDTH-1:0] mask;
    logic                  wr;
    logic                  pop;

    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            mask[i] = i < data_bits(cfg_data_bit_num);
    end

    // a full FIFO leaves rx_done unacknowledged, which backpressures the receiver
    assign wr    = state == ST_IDLE && rx_done && !full;
    assign pop   = rd_en && !empty;
    assign empty = level == '0;
    assign full  = level == LW'(DEPTH);
    assign irq   = cfg_threshold != '0 && level >= cfg_threshold;

    dti_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (rx_data & mask),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rx_done_ack <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            rx_done_ack <= wr;
            underflow   <= (rd_en && empty) || (underflow && !clr_err);
            state       <= (state == ST_IDLE) ? (wr ? ST_ACK : ST_IDLE) :
                           (state == ST_ACK)  ? ST_WAIT_CLR :
                           (rx_done ? ST_WAIT_CLR : ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench driving receiver handshakes and host pops into uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [1:0] cfg_data_bit_num;
    logic [4:0] cfg_threshold;
    logic       rx_done_ack;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       irq;
    logic       underflow;
    logic       clr_err;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         exp_lvl = 0;
    logic [7:0] sb[$];
    logic [7:0] last;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_done          (rx_done),
        .rx_data          (rx_data),
        .cfg_data_bit_num (cfg_data_bit_num),
        .cfg_threshold    (cfg_threshold),
        .rx_done_ack      (rx_done_ack),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .empty            (empty),
        .full             (full),
        .level            (level),
        .irq              (irq),
        .underflow        (underflow),
        .clr_err          (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(input logic [1:0] w);
        logic [8:0] m;
        m = 9'd1 << (5 + int'(w));
        return 8'(m - 9'd1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int hold);
        int n;
        n = 0;
        rx_data = d;
        rx_done = 1'b1;
        sb.push_back(d & mask_of(cfg_data_bit_num));
        do begin
            tick;
            n++;
        end while (!rx_done_ack && n < 40);
        check("ack_latency", n, 1);
        exp_lvl++;
        check("level_after_write", level, exp_lvl);
        repeat (hold) begin
            tick;
            check("no_dup_ack", rx_done_ack, 0);
        end
        rx_done = 1'b0;
        tick;
        check("ack_one_cycle", rx_done_ack, 0);
        tick;
        check("no_dup_write", level, exp_lvl);
    endtask

    task automatic pop;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            last = sb.pop_front();
            check("rd_data", rd_data, last);
        end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        exp_lvl--;
        check("level_after_pop", level, exp_lvl);
    endtask

    initial begin
        int n;
        logic [7:0] d17;
        reset = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        cfg_data_bit_num = 2'b11;
        cfg_threshold = '0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_irq", irq, 0);
        check("rst_level", level, 0);
        check("rst_ack", rx_done_ack, 0);
        check("rst_underflow", underflow, 0);

        send(8'hA5, 3);
        check("a5_head", rd_data, 8'hA5);
        pop;

        cfg_data_bit_num = 2'b00;
        send(8'hFF, 0);
        cfg_data_bit_num = 2'b10;
        send(8'hFF, 0);
        cfg_data_bit_num = 2'b01;
        send(8'hFF, 1);
        cfg_data_bit_num = 2'b11;
        pop;
        pop;
        pop;
        check("empty_after_drain", empty, 1);
        check("rd_data_last_popped", rd_data, last);

        cfg_threshold = 5'd4;
        repeat (3) send(8'($urandom), 0);
        check("irq_below_thr", irq, 0);
        send(8'($urandom), 0);
        check("irq_at_thr", irq, 1);
        pop;
        check("irq_drop_at_3", irq, 0);
        cfg_threshold = '0;
        check("irq_thr_zero", irq, 0);

        rx_data = 8'h5A;
        rx_done = 1'b1;
        check("wr_pop_head", rd_data, sb[0]);
        void'(sb.pop_front());
        sb.push_back(8'h5A);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("wr_pop_level", level, exp_lvl);
        check("wr_pop_ack", rx_done_ack, 1);
        rx_done = 1'b0;
        tick;
        tick;
        while (sb.size() > 0) pop;

        for (int i = 0; i < 16; i++) send(8'($urandom), 0);
        check("full_set", full, 1);
        check("full_level", level, 16);
        d17 = 8'($urandom);
        rx_data = d17;
        rx_done = 1'b1;
        repeat (4) begin
            tick;
            check("full_no_ack", rx_done_ack, 0);
        end
        check("full_no_write", level, 16);
        check("full_pop_head", rd_data, sb[0]);
        void'(sb.pop_front());
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("full_pop_only", level, 15);
        check("full_pop_no_ack", rx_done_ack, 0);
        n = 0;
        while (!rx_done_ack && n < 20) begin
            tick;
            n++;
        end
        check("bp_release_ack", rx_done_ack, 1);
        check("bp_release_level", level, 16);
        sb.push_back(d17);
        exp_lvl = 16;
        rx_done = 1'b0;
        tick;
        tick;
        while (sb.size() > 0) pop;
        check("drain_empty", empty, 1);
        check("drain_last", rd_data, d17);

        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("underflow_set", underflow, 1);
        check("underflow_level", level, 0);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        check("underflow_clr", underflow, 0);
        rd_en = 1'b1;
        tick;
        clr_err = 1'b1;
        tick;
        rd_en = 1'b0;
        clr_err = 1'b0;
        check("underflow_clr_vs_set", underflow, 1);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        check("underflow_clr2", underflow, 0);

        rx_data = 8'h3C;
        rx_done = 1'b1;
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("wr_empty_rd_level", level, 1);
        check("wr_empty_rd_uflow", underflow, 1);
        check("wr_empty_rd_ack", rx_done_ack, 1);
        sb.push_back(8'h3C);
        exp_lvl = 1;
        rx_done = 1'b0;
        tick;
        tick;
        pop;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;

        repeat (4) send(8'($urandom), 0);
        rx_data = 8'hC3;
        rx_done = 1'b1;
        n = 0;
        while (!rx_done_ack && n < 20) begin
            tick;
            n++;
        end
        check("pre_reset_ack", rx_done_ack, 1);
        tick;
        check("pre_reset_level", level, 5);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ack", rx_done_ack, 0);
        sb.delete();
        exp_lvl = 0;
        tick;
        check("dup_after_rst_ack", rx_done_ack, 1);
        check("dup_after_rst_level", level, 1);
        sb.push_back(8'hC3);
        exp_lvl = 1;
        rx_done = 1'b0;
        tick;
        tick;
        pop;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
